// File: rtl/simd_pkg.sv
//------------------------------------------------------------------------------
// Module      : simd_pkg
// Description : Shared widths, opcodes and loader state encodings for the SIMD block.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package simd_pkg;

    localparam int DATA_W = 16;
    localparam int LINES  = 10;
    localparam int ADDR_W = 4;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_MAX = 2'b01;
    localparam logic [1:0] OP_XOR = 2'b10;

    localparam logic [1:0] ST_IDLE    = 2'b00;
    localparam logic [1:0] ST_LOAD_HI = 2'b01;
    localparam logic [1:0] ST_LOAD_LO = 2'b10;
    localparam logic [1:0] ST_DONE    = 2'b11;

endpackage

`default_nettype wire

// File: rtl/simd_line_mem.sv
//------------------------------------------------------------------------------
// Module      : simd_line_mem
// Description : LINES x 2*DATA_W register file, lines 1..LINES, sync clear,
//               one write port and one combinational read port.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module simd_line_mem #(
    parameter int DATA_W = simd_pkg::DATA_W,
    parameter int LINES  = simd_pkg::LINES,
    parameter int ADDR_W = simd_pkg::ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [2*DATA_W-1:0]   wdata,
    input  logic [ADDR_W-1:0]     x,
    output logic [2*DATA_W-1:0]   rd_line
);

    logic [2*DATA_W-1:0] r_lines [1:LINES];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i <= LINES; i++) begin
                r_lines[i] <= '0;
            end
        end else if (we) begin
            for (int i = 1; i <= LINES; i++) begin
                if (waddr == ADDR_W'(i)) begin
                    r_lines[i] <= wdata;
                end
            end
        end
    end

    // Address 0 and anything above LINES match no line and read as zero.
    always_comb begin
        rd_line = '0;
        for (int i = 1; i <= LINES; i++) begin
            if (x == ADDR_W'(i)) begin
                rd_line = r_lines[i];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/simd_operand_loader.sv
//------------------------------------------------------------------------------
// Module      : simd_operand_loader
// Description : Packs a halfword stream into {hi, lo} lines 1..LINES of the
//               SIMD operand memory and exposes a combinational lane read port.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module simd_operand_loader
    import simd_pkg::*;
#(
    parameter int DATA_W = simd_pkg::DATA_W,
    parameter int LINES  = simd_pkg::LINES,
    parameter int ADDR_W = simd_pkg::ADDR_W
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic [DATA_W-1:0]     in_data,
    output logic                  busy,
    output logic                  done,
    input  logic [ADDR_W-1:0]     x,
    output logic [2*DATA_W-1:0]   rd_line
);

    localparam logic [ADDR_W-1:0] C_FIRST_ADDR = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] C_LAST_ADDR  = ADDR_W'(LINES);

    logic [1:0]          r_state;
    logic [ADDR_W-1:0]   r_addr;
    logic [DATA_W-1:0]   r_hi_q;
    logic                w_loading;
    logic                w_we;

    // Ready is a pure state decode so the producer never sees a combinational loop.
    assign w_loading = (r_state == ST_LOAD_HI) || (r_state == ST_LOAD_LO);
    assign in_ready  = w_loading;
    assign busy      = w_loading;
    assign done      = (r_state == ST_DONE);
    assign w_we      = (r_state == ST_LOAD_LO) && in_valid;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_addr  <= C_FIRST_ADDR;
            r_hi_q  <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (start) begin
                        r_state <= ST_LOAD_HI;
                        r_addr  <= C_FIRST_ADDR;
                    end
                end
                ST_LOAD_HI: begin
                    if (in_valid) begin
                        r_hi_q  <= in_data;
                        r_state <= ST_LOAD_LO;
                    end
                end
                ST_LOAD_LO: begin
                    if (in_valid) begin
                        if (r_addr == C_LAST_ADDR) begin
                            r_state <= ST_DONE;
                        end else begin
                            r_addr  <= r_addr + C_FIRST_ADDR;
                            r_state <= ST_LOAD_HI;
                        end
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    simd_line_mem #(
        .DATA_W (DATA_W),
        .LINES  (LINES),
        .ADDR_W (ADDR_W)
    ) u_line_mem (
        .clk     (clk),
        .rst     (rst),
        .we      (w_we),
        .waddr   (r_addr),
        .wdata   ({r_hi_q, in_data}),
        .x       (x),
        .rd_line (rd_line)
    );

endmodule

`default_nettype wire

// File: tb/tb_simd_operand_loader.sv
//------------------------------------------------------------------------------
// Module      : tb_simd_operand_loader
// Description : Scoreboard bench for the SIMD operand loader.
// Revision    : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_simd_operand_loader;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] in_data;
    logic        busy;
    logic        done;
    logic [3:0]  x;
    logic [31:0] rd_line;

    int          checks   = 0;
    int          failures = 0;
    logic [31:0] sb_q [$];
    logic [31:0] model [1:10];

    always #5 clk = ~clk;

    simd_operand_loader dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .in_data  (in_data),
        .busy     (busy),
        .done     (done),
        .x        (x),
        .rd_line  (rd_line)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        for (int i = 1; i <= 10; i++) begin
            x = 4'(i);
            #1;
            chk(tag, rd_line, 32'h0);
        end
    endtask

    // One full load: halfword k (0-based) is base+k+1; optional stalls and start pokes.
    task automatic load(input logic [15:0] base, input bit gap, input bit poke_start);
        int          cyc;
        int          idx;
        int          ln;
        bit          acc;
        logic [15:0] hi;
        logic [31:0] exp;
        hi    = '0;
        start = 1'b1;
        tick();
        start = 1'b0;
        cyc   = 1;
        idx   = 0;
        chk("busy_after_start", {31'b0, busy}, 32'h1);
        while (idx < 20 && cyc < 100) begin
            in_valid = !(gap && (cyc % 2 == 1));
            in_data  = base + 16'(idx) + 16'd1;
            start    = poke_start && (idx == 6);
            ln       = idx / 2 + 1;
            x        = 4'(ln);
            #1;
            chk("ready_while_busy", {31'b0, in_ready}, 32'h1);
            chk("no_early_done", {31'b0, done}, 32'h0);
            acc = in_valid;
            if (acc && (idx % 2 == 1)) begin
                chk("same_cycle_read_old", rd_line, model[ln]);
                exp = {hi, in_data};
                sb_q.push_back(exp);
            end
            if (acc && (idx % 2 == 0)) hi = in_data;
            tick();
            cyc++;
            if (acc) begin
                if (idx % 2 == 1) begin
                    model[ln] = exp;
                    chk("read_after_write", rd_line, exp);
                end
                idx++;
            end
        end
        in_valid = 1'b0;
        start    = poke_start;
        chk("handshakes", 32'(idx), 32'd20);
        chk("done_pulse", {31'b0, done}, 32'h1);
        chk("done_latency", 32'(cyc), gap ? 32'd41 : 32'd21);
        tick();
        start = 1'b0;
        chk("done_one_cycle", {31'b0, done}, 32'h0);
        chk("idle_after_done", {31'b0, busy}, 32'h0);
        tick();
        chk("no_requeued_start", {31'b0, busy}, 32'h0);
        chk("no_second_done", {31'b0, done}, 32'h0);
        for (int i = 1; i <= 10; i++) begin
            x = 4'(i);
            #1;
            if (sb_q.size() == 0) begin
                chk("scoreboard_empty", 32'(i), 32'd0);
            end else begin
                exp = sb_q.pop_front();
                chk("line_contents", rd_line, exp);
            end
        end
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        x        = '0;
        for (int i = 1; i <= 10; i++) model[i] = '0;
        tick();
        tick();
        rst = 1'b0;

        // Reset state
        chk("rst_in_ready", {31'b0, in_ready}, 32'h0);
        chk("rst_busy", {31'b0, busy}, 32'h0);
        chk("rst_done", {31'b0, done}, 32'h0);
        check_all_zero("rst_line_zero");

        // Back-to-back stream, then stalls on alternate cycles, then start pokes
        load(16'h0000, 1'b0, 1'b0);
        load(16'h0000, 1'b1, 1'b0);
        load(16'h0200, 1'b0, 1'b1);

        // Reset after 7 halfwords aborts the load
        start = 1'b1;
        tick();
        start    = 1'b0;
        in_valid = 1'b1;
        for (int k = 0; k < 7; k++) begin
            in_data = 16'h0050 + 16'(k) + 16'd1;
            tick();
        end
        x = 4'd1;
        #1;
        chk("partial_line1", rd_line, 32'h00510052);
        in_data = 16'h00ff;
        rst     = 1'b1;
        tick();
        rst      = 1'b0;
        in_valid = 1'b0;
        chk("abort_busy", {31'b0, busy}, 32'h0);
        chk("abort_in_ready", {31'b0, in_ready}, 32'h0);
        chk("abort_done", {31'b0, done}, 32'h0);
        check_all_zero("abort_line_zero");
        for (int i = 1; i <= 10; i++) model[i] = '0;
        tick();
        chk("abort_still_idle", {31'b0, busy}, 32'h0);
        load(16'h0100, 1'b0, 1'b0);

        // Out-of-range addresses
        x = 4'd0;
        #1;
        chk("x0_zero", rd_line, 32'h0);
        x = 4'd11;
        #1;
        chk("x11_zero", rd_line, 32'h0);
        x = 4'd15;
        #1;
        chk("x15_zero", rd_line, 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

`default_nettype wire
